// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake key conditioning path.
package snake_pkg;

  localparam int NUM_KEYS = 4;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } req_state_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, stability counter, debounced level and press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_n_o,
  output logic fall_o
);

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Mismatch has held for the full window: accept the new level.
        level_q <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_n_o = level_q;
  assign fall_o    = fall_q;

endmodule

// File: rtl/snake_key_conditioner.sv
// Debounces the four KEY inputs and turns accepted presses into a tick-committed
// snake direction, rejecting no-op and 180-degree requests.
module snake_key_conditioner
  import snake_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
  parameter logic [1:0]  INIT_DIR        = 2'd0
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_i,
  input  logic                move_tick_i,
  output logic [NUM_KEYS-1:0] pressed_n_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [1:0]          dir_o,
  output logic                dir_change_o,
  output logic                pending_o
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk_i    (clk_clk),
      .rst_i    (reset_reset),
      .key_n_i  (key_n_i[g]),
      .level_n_o(pressed_n_o[g]),
      .fall_o   (press_o[g])
    );
  end

  req_state_t state_q;
  dir_t       dir_q, pend_dir_q;
  logic       dir_change_q;

  dir_t cand;
  dir_t base;
  logic cand_valid;

  // Lowest-index press wins when several are accepted together.
  always_comb begin
    cand = DIR_RIGHT;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_o[i]) cand = dir_t'(2'(i));
    end
    base       = (move_tick_i && state_q == ST_PENDING) ? pend_dir_q : dir_q;
    cand_valid = (|press_o) && (cand != base) && (cand != opposite(base));
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= dir_t'(INIT_DIR);
      pend_dir_q   <= dir_t'(INIT_DIR);
      dir_change_q <= 1'b0;
    end else begin
      dir_change_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cand_valid) begin
            pend_dir_q <= cand;
            state_q    <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (move_tick_i) begin
            // Commit, and let a same-cycle press chain on from the new heading.
            dir_q        <= pend_dir_q;
            dir_change_q <= 1'b1;
            if (cand_valid) pend_dir_q <= cand;
            else            state_q    <= ST_IDLE;
          end else if (cand_valid) begin
            pend_dir_q <= cand;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dir_o        = dir_q;
  assign dir_change_o = dir_change_q;
  assign pending_o    = (state_q == ST_PENDING);

endmodule
